// File: rtl/panda_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// No logic: register offsets, STATUS bit positions, serialiser states.
// No flow control of its own.
package panda_uart_pkg;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_BAUD_DIV = 2'd2;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/panda_uart_if.sv
// Core data-port bus shared with data RAM: ce/we/addr/wdata, registered read data.
// Read data appears the cycle after a read access.
// No backpressure: every access completes in one cycle.
interface panda_uart_if;
    logic        ce;
    logic [3:0]  we;
    logic [3:0]  addr;
    logic [31:0] wr_dat;
    logic [31:0] rd_dat;

    modport master (output ce, we, addr, wr_dat, input rd_dat);
    modport slave  (input ce, we, addr, wr_dat, output rd_dat);
endinterface

// File: rtl/panda_fifo.sv
// Generic synchronous FIFO with occupancy count; Depth must be a power of two.
// Zero-cycle read: pop_dat always shows the head entry.
// Push ignored when full, pop ignored when empty; caller watches full/empty.
module panda_fifo #(
    parameter int DataWidth = 8,
    parameter int Depth     = 8,
    localparam int PtrW     = $clog2(Depth),
    localparam int CntW     = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_dat,
    input  logic                 pop,
    output logic [DataWidth-1:0] pop_dat,
    output logic                 full,
    output logic                 empty,
    output logic [CntW-1:0]      count
);

    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic                 push_ok, pop_ok;

    assign full    = (count == FullCnt);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

endmodule

// File: rtl/panda_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, baud counter, serialiser.
// Reads return one cycle after access; first start bit one cycle after the push.
// Never stalls the core: pushes to a full FIFO are dropped and flagged in STATUS.overflow.
module panda_uart_tx
    import panda_uart_pkg::*;
#(
    parameter int          FifoDepth      = 8,
    parameter logic [15:0] DefaultBaudDiv = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    panda_uart_if.slave bus,
    output logic        tx_o,
    output logic        tx_empty_o
);

    localparam int CntW = $clog2(FifoDepth + 1);

    logic            reg_rd, reg_wr, push, pop;
    logic [1:0]      reg_sel;
    logic [7:0]      fifo_dat;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            overflow_q;
    logic [15:0]     baud_div_q, period;
    logic [31:0]     rd_mux, rd_dat_q;
    uart_state_e     state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_d, tick;
    logic            unused_bits;

    assign reg_sel     = bus.addr[3:2];
    assign reg_rd      = bus.ce && (bus.we == 4'b0000);
    assign reg_wr      = bus.ce && (bus.we != 4'b0000);
    assign push        = reg_wr && (reg_sel == REG_TXDATA) && bus.we[0];
    assign unused_bits = ^{bus.addr[1:0], bus.wr_dat[31:16]};

    panda_fifo #(
        .DataWidth (8),
        .Depth     (FifoDepth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push),
        .push_dat (bus.wr_dat[7:0]),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            baud_div_q <= DefaultBaudDiv;
            rd_dat_q   <= '0;
        end else begin
            // A drop is judged on the registered full flag; a same-cycle pop does not make room.
            if (push && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (reg_wr && reg_sel == REG_STATUS && bus.we[0] && bus.wr_dat[ST_OVERFLOW]) begin
                overflow_q <= 1'b0;
            end
            if (reg_wr && reg_sel == REG_BAUD_DIV) begin
                if (bus.we[0]) baud_div_q[7:0]  <= bus.wr_dat[7:0];
                if (bus.we[1]) baud_div_q[15:8] <= bus.wr_dat[15:8];
            end
            if (reg_rd) begin
                rd_dat_q <= rd_mux;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_mux[ST_BUSY]              = (state_q != IDLE);
                rd_mux[ST_FULL]              = fifo_full;
                rd_mux[ST_EMPTY]             = fifo_empty;
                rd_mux[ST_OVERFLOW]          = overflow_q;
                rd_mux[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
            end
            REG_BAUD_DIV: rd_mux[15:0] = baud_div_q;
            default: ;
        endcase
    end

    assign bus.rd_dat = rd_dat_q;
    assign tx_empty_o = fifo_empty && (state_q == IDLE);

    // Period is sampled only on reload, so divider writes land on the next bit boundary.
    assign period = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;
    assign tick   = (cnt_q == 16'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_o    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_o    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dat;
                    cnt_d   = period;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_d   = period;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d = period;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dat;
                        cnt_d   = period;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
        // Line level follows the next state so tx_o comes straight from a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_panda_uart_tx.sv
// Bench for panda_uart_tx: register vectors, serial-frame scoreboard, timing corner cases.
module tb_panda_uart_tx;

    logic clk = 1'b0;
    logic rst_ni;
    logic tx_o;
    logic tx_empty_o;

    panda_uart_if bus();

    panda_uart_tx #(
        .FifoDepth      (8),
        .DefaultBaudDiv (16'd868)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .bus        (bus),
        .tx_o       (tx_o),
        .tx_empty_o (tx_empty_o)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;
    int         bit_p  = 4;

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  we;
        logic [31:0] wdat;
        logic [3:0]  rd_addr;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[8];

    logic [31:0] rd;
    logic [9:0]  frame;
    logic [19:0] frame2;
    int          wave_err;
    int          aux_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.ce = 1'b1; bus.we = be; bus.addr = a; bus.wr_dat = d;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.ce = 1'b0; bus.we = 4'b0000;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.ce = 1'b1; bus.we = 4'b0000; bus.addr = a;
        @(negedge clk);
        bus.ce = 1'b0;
        d = bus.rd_dat;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        bus_write(4'h0, {24'h0, b}, 4'b0001);
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!tx_empty_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(tx_empty_o), 32'd1);
    endtask

    // Expected line level k cycles after the start edge: first nfast slots last p1, rest p2.
    function automatic logic lvl_at(input logic [9:0] fr, input int k, input int p1, input int p2,
                                    input int nfast);
        int t = k;
        for (int s = 0; s < 10; s++) begin
            int d = (s < nfast) ? p1 : p2;
            if (t < d) return fr[s];
            t -= d;
        end
        return 1'b1;
    endfunction

    initial begin : monitor
        logic [7:0] b;
        logic       stop_bit;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_ni && tx_o == 1'b0) begin
                repeat (bit_p / 2) @(negedge clk);
                chk("frame_start_mid", 32'(tx_o), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (bit_p) @(negedge clk);
                    b[i] = tx_o;
                end
                repeat (bit_p) @(negedge clk);
                stop_bit = tx_o;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got 0x%02h expected no frame", b);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_data", 32'(b), 32'(e));
                end
                chk("frame_stop", 32'(stop_bit), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        bus.ce = 1'b0; bus.we = 4'b0000; bus.addr = 4'h0; bus.wr_dat = '0;
        vecs[0] = '{4'h8, 4'b0011, 32'h0000_1234, 4'h8, 32'h0000_1234};
        vecs[1] = '{4'h8, 4'b0001, 32'hFFFF_00AB, 4'h8, 32'h0000_12AB};
        vecs[2] = '{4'h8, 4'b0010, 32'hFFFF_CD00, 4'h8, 32'h0000_CDAB};
        vecs[3] = '{4'h8, 4'b1100, 32'hFFFF_FFFF, 4'h8, 32'h0000_CDAB};
        vecs[4] = '{4'hC, 4'b1111, 32'hFFFF_FFFF, 4'hC, 32'h0000_0000};
        vecs[5] = '{4'h4, 4'b0001, 32'h0000_0008, 4'h4, 32'h0000_0004};
        vecs[6] = '{4'h8, 4'b0011, 32'h0000_0004, 4'h0, 32'h0000_0000};
        vecs[7] = '{4'h0, 4'b0000, 32'h0000_0000, 4'h8, 32'h0000_0004};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_tx_empty", 32'(tx_empty_o), 32'd1);
        chk("rst_data_o", bus.rd_dat, 32'd0);
        rst_ni = 1'b1;
        bus_read(4'h4, rd); chk("rst_status", rd, 32'h0000_0004);
        bus_read(4'h8, rd); chk("rst_baud", rd, 32'd868);

        // Register vectors; leaves BAUD_DIV = 4
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we != 4'b0000) bus_write(vecs[i].addr, vecs[i].wdat, vecs[i].we);
            bus_read(vecs[i].rd_addr, rd);
            chk($sformatf("vec%0d", i), rd, vecs[i].exp_rd);
        end

        // Single byte, cycle-exact waveform
        bit_p = 4; mon_en = 1'b1;
        push_byte(8'h55, 1'b1);
        bus_idle();
        chk("t2_pre_start_tx", 32'(tx_o), 32'd1);
        chk("t2_pre_start_empty", 32'(tx_empty_o), 32'd0);
        frame = {1'b1, 8'h55, 1'b0};
        wave_err = 0; aux_err = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_o !== frame[k / 4]) wave_err++;
            if (tx_empty_o !== 1'b0) aux_err++;
        end
        @(negedge clk);
        chk("t2_wave_errs", 32'(wave_err), 32'd0);
        chk("t2_busy_errs", 32'(aux_err), 32'd0);
        chk("t2_empty_at_40", 32'(tx_empty_o), 32'd1);

        // Back-to-back frames with no idle gap
        push_byte(8'hA5, 1'b1);
        push_byte(8'h3C, 1'b1);
        bus_idle();
        frame2 = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        wave_err = 0; aux_err = 0;
        for (int k = 0; k <= 80; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 80) begin
                if (tx_o !== frame2[k / 4]) wave_err++;
                if (tx_empty_o !== 1'b0) aux_err++;
            end
        end
        chk("t3_wave_errs", 32'(wave_err), 32'd0);
        chk("t3_busy_errs", 32'(aux_err), 32'd0);
        chk("t3_empty_at_80", 32'(tx_empty_o), 32'd1);
        wait_idle(50);
        mon_en = 1'b0;

        // Divider change during data bit 3
        push_byte(8'hA5, 1'b0);
        bus_idle();
        frame = {1'b1, 8'hA5, 1'b0};
        wave_err = 0;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (tx_o !== lvl_at(frame, k, 4, 8, 5)) wave_err++;
            if (k == 16) begin
                bus.ce = 1'b1; bus.we = 4'b0011; bus.addr = 4'h8; bus.wr_dat = 32'd8;
            end
            if (k == 17) begin
                bus.ce = 1'b0; bus.we = 4'b0000;
            end
        end
        chk("t5_wave_errs", 32'(wave_err), 32'd0);
        chk("t5_empty_at_60", 32'(tx_empty_o), 32'd1);

        // BAUD_DIV = 0 runs at one cycle per bit
        bus_write(4'h8, 32'd0, 4'b0011);
        push_byte(8'h96, 1'b0);
        bus_idle();
        frame = {1'b1, 8'h96, 1'b0};
        wave_err = 0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (tx_o !== lvl_at(frame, k, 1, 1, 10)) wave_err++;
        end
        chk("t5_div0_wave_errs", 32'(wave_err), 32'd0);
        chk("t5_div0_empty", 32'(tx_empty_o), 32'd1);

        // Overflow: one popped, eight queued, one dropped
        bus_write(4'h8, 32'd1000, 4'b0011);
        for (int i = 0; i < 10; i++) push_byte(8'(i), 1'b0);
        bus_idle();
        bus_read(4'h4, rd); chk("t4_status_ovf", rd, 32'h0000_080B);
        bus_write(4'h4, 32'h0000_0008, 4'b0001);
        bus_idle();
        bus_read(4'h4, rd); chk("t4_status_w1c", rd, 32'h0000_0803);
        chk("t4_not_empty", 32'(tx_empty_o), 32'd0);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Asynchronous reset during DATA with three bytes queued
        bus_write(4'h8, 32'd4, 4'b0011);
        for (int i = 0; i < 4; i++) push_byte(8'h00, 1'b0);
        bus_idle();
        repeat (4) @(negedge clk);
        chk("t6_in_data_low", 32'(tx_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_tx_async_high", 32'(tx_o), 32'd1);
        chk("t6_empty_async", 32'(tx_empty_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        bus_read(4'h4, rd); chk("t6_status", rd, 32'h0000_0004);
        bus_read(4'h8, rd); chk("t6_baud_reset", rd, 32'd868);
        aux_err = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || tx_empty_o !== 1'b1) aux_err++;
        end
        chk("t6_no_frames", 32'(aux_err), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
